imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of the single-cycle processor: receives a program as a byte stream (valid/ready),
//  packs bytes into 32-bit little-endian words and writes them sequentially into instruction
//  memory starting at word 0. Holds the processor in reset while loading and releases it only
//  after a complete, checksum-verified image has been written.
// PARAMETERS
//  WORD_SIZE       32         instruction/data word width (fixed 32; byte packing assumes 4 bytes)
//  ADDR_W          8          instruction memory word-address width (256 words, matches pc[9:2])
//  TIMEOUT_CYCLES  1000000    max idle cycles between bytes once a load has started
// PORTS
//  clk            in   1         system clock, all state on rising edge
//  rst            in   1         synchronous, active-high reset
//  in_valid       in   1         byte stream valid
//  in_data        in   8         byte stream data
//  in_ready       out  1         loader can accept a byte this cycle
//  imem_we        out  1         instruction memory write strobe (one cycle per word)
//  imem_addr      out  ADDR_W    word address for imem_we
//  imem_wdata     out  WORD_SIZE word to write
//  cpu_rst        out  1         reset to processor; 1 until image accepted
//  load_done      out  1         image loaded and verified (sticky until rst)
//  load_error     out  1         length/checksum/timeout error (sticky until rst)
//  words_loaded   out  ADDR_W+1  count of words written so far
// BEHAVIOUR
//  Image format: LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes (LSB first per word), CSUM.
//  Byte accepted on any edge with in_valid & in_ready. in_data may change only after acceptance.
//  Reset: state=HDR0, in_ready=0 for the reset cycle then 1, imem_we=0, imem_addr=0, imem_wdata=0,
//   cpu_rst=1, load_done=0, load_error=0, words_loaded=0, running XOR=0, timeout counter=0.
//  States: HDR0 -> HDR1 -> (DATA | CSUM) -> DONE; any of HDR1/DATA/CSUM -> ERR.
//   HDR0: accept LEN_LO -> HDR1. No timeout in HDR0 (waits indefinitely).
//   HDR1: accept LEN_HI; if N > 2**ADDR_W -> ERR; if N==0 -> CSUM; else -> DATA, byte index=0.
//   DATA: byte k of word goes to bits [8k+7:8k] of assembly register; on 4th byte accepted,
//    next cycle imem_we=1 for exactly one cycle with imem_addr=word index, imem_wdata=packed word,
//    words_loaded increments in same cycle. After word N-1 -> CSUM. in_ready stays 1 (no stall).
//   CSUM: accept byte; if byte == XOR of all prior bytes (LEN_LO..last data) -> DONE else -> ERR.
//   DONE: in_ready=0, cpu_rst=0, load_done=1. Ignores input until rst.
//   ERR:  in_ready=0, cpu_rst=1, load_error=1. No further memory writes. Exit only via rst.
//  Timeout: counter clears on each accepted byte and on state entry; counts in HDR1/DATA/CSUM;
//   when it reaches TIMEOUT_CYCLES-1 with no byte accepted, next state ERR. Partial words are not written.
//  N == 2**ADDR_W is legal: last word at address 2**ADDR_W-1, words_loaded = 2**ADDR_W (no wrap).
//  Last-word write strobe and transition to CSUM may coincide with CSUM byte arriving next cycle;
//   CSUM byte is accepted in the cycle imem_we is high.
//  cpu_rst deasserts in the cycle after the CSUM byte is accepted (same cycle load_done rises).
//  rst mid-load: all state returns to reset values immediately; memory contents left as-is.
// TESTING
//  1) N=1: bytes 01 00 13 00 08 20 3A -> one imem_we, addr 0, wdata 0x20080013; load_done=1, cpu_rst=0.
//  2) N=2 with in_valid gaps of 5 cycles between bytes -> writes at addr 0,1; words_loaded=2; done.
//  3) Bad checksum (N=1, CSUM=0x00 for data above) -> word written, load_error=1, cpu_rst stays 1.
//  4) N=0x0101 with ADDR_W=8 -> ERR right after LEN_HI, zero imem_we pulses, in_ready=0.
//  5) TIMEOUT_CYCLES=16, stop after 2 data bytes -> ERR after 16 idle cycles, no imem_we.
//  6) rst asserted mid-DATA then full valid N=1 image -> clean load to addr 0, load_done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and packs it into
// 32-bit little-endian words in instruction memory, holding the CPU in reset until it verifies.
module imem_boot_loader #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_SIZE-1:0] imem_wdata,
    output logic                 cpu_rst,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      words_loaded
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]  WORD_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [16:0]        len_words;
    logic [1:0]         byte_idx;
    logic [23:0]        asm_word;
    logic [7:0]         xor_acc;
    logic [CNT_W-1:0]   timeout_cnt;

    logic               accept;
    logic [16:0]        hdr_len;
    logic [16:0]        next_count;
    logic               timed_out;

    assign accept     = in_valid & in_ready;
    assign hdr_len    = {1'b0, in_data, len_lo};
    assign next_count = 17'(words_loaded) + 17'd1;
    assign timed_out  = (timeout_cnt == TO_LAST);

    // Single state machine; every output is a register so the CPU and memory see clean edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_HDR0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len_words    <= '0;
            byte_idx     <= '0;
            asm_word     <= '0;
            xor_acc      <= '0;
            timeout_cnt  <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_HDR0: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        len_lo      <= in_data;
                        xor_acc     <= xor_acc ^ in_data;
                        timeout_cnt <= '0;
                        state       <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (accept) begin
                        xor_acc     <= xor_acc ^ in_data;
                        timeout_cnt <= '0;
                        len_words   <= hdr_len;
                        byte_idx    <= '0;
                        if (hdr_len > MAX_WORDS) begin
                            state      <= S_ERR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else if (hdr_len == 17'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (timed_out) begin
                        state      <= S_ERR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        xor_acc     <= xor_acc ^ in_data;
                        timeout_cnt <= '0;
                        byte_idx    <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= in_data;
                            2'd1: asm_word[15:8]  <= in_data;
                            2'd2: asm_word[23:16] <= in_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= words_loaded[ADDR_W-1:0];
                                imem_wdata   <= WORD_SIZE'({in_data, asm_word});
                                words_loaded <= words_loaded + WORD_ONE;
                                if (next_count == len_words) begin
                                    state <= S_CSUM;
                                end
                            end
                        endcase
                    end else if (timed_out) begin
                        state      <= S_ERR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_ONE;
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        in_ready    <= 1'b0;
                        timeout_cnt <= '0;
                        if (in_data == xor_acc) begin
                            state     <= S_DONE;
                            cpu_rst   <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state      <= S_ERR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_ONE;
                    end
                end

                S_DONE: begin
                    in_ready <= 1'b0;
                end

                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
